// File: rtl/spectrum_pkg.sv
// Shared constants, FSM encodings and the bin-index-to-band map for spectrum_band_builder.
package spectrum_pkg;

  localparam int NUM_BANDS = 8;
  localparam int LEVEL_W   = 8;

  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] FINAL   = 2'd1;
  localparam logic [1:0] PUBLISH = 2'd2;

  // Band k holds indices 2^k .. 2^(k+1)-1, i.e. the MSB position of the index.
  function automatic logic [2:0] band_of(input logic [7:0] idx);
    logic [2:0] b;
    b = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (idx[i]) b = 3'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/log2_fixed.sv
// Combinational 8.8 log2: integer part is the leading-one position, fraction is the
// next 8 bits below it, left-aligned (zero-padded for small inputs). Zero input gives 0.
module log2_fixed #(
  parameter int W = 24
) (
  input  logic [W-1:0] x_i,
  output logic [15:0]  y_o
);

  logic [7:0]   msb;
  logic [7:0]   shamt;
  logic [W-2:0] norm;
  logic         norm_unused;

  always_comb begin
    msb = 8'd0;
    for (int i = 1; i < W; i++) begin
      if (x_i[i]) msb = 8'(i);
    end
    // Shift the leading one up to bit W-1 (dropped); the fraction then sits just below.
    shamt       = 8'(W - 1) - msb;
    norm        = x_i[W-2:0] << shamt;
    norm_unused = ^norm[W-10:0];
    y_o         = (x_i == '0) ? 16'h0000 : {msb, norm[W-2 -: 8]};
  end

endmodule

// File: rtl/spectrum_band_builder.sv
// FFT bins -> eight octave bar levels + 8.8 log2 frame energy; strobe 9 cycles after bin_last,
// bin_ready low for those 9 cycles. Define SPECTRUM_PEAK_HOLD_EN for decaying peak-hold bars.
module spectrum_band_builder
  import spectrum_pkg::*;
#(
  parameter int BIN_W       = 16,
  parameter int LEVEL_SHIFT = 4,
  parameter int DECAY_STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bin_valid,
  input  logic [BIN_W-1:0] bin_data,
  input  logic             bin_last,
  output logic             bin_ready,
  output logic [63:0]      spectrum_data_flat,
  output logic [15:0]      db_value,
  output logic             spectrum_valid
);

  localparam int SUM_W = BIN_W + 7;
  localparam int TOT_W = BIN_W + 8;

  logic [1:0]         state_q, state_d;
  logic [7:0]         idx_q;
  logic               full_q;
  logic [2:0]         b_q;
  logic [SUM_W-1:0]   sum_q  [NUM_BANDS];
  logic [TOT_W-1:0]   total_q;
  logic [LEVEL_W-1:0] held_q [NUM_BANDS];
  logic [LEVEL_W-1:0] held_d [NUM_BANDS];
  logic [LEVEL_W-1:0] new_lvl, upd_lvl;
  logic [SUM_W-1:0]   avg, lvl;
  logic [63:0]        flat_d, flat_q;
  logic [15:0]        db_d, db_q;
  logic               valid_q;
  logic               xfer, take;

  assign bin_ready = (state_q == ACCUM) && !rst;
  assign xfer      = bin_valid && bin_ready;
  // DC (index 0) and anything past index 255 are consumed but not accumulated.
  assign take      = xfer && !full_q && (idx_q != 8'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (xfer && bin_last) state_d = FINAL;
      FINAL:   if (b_q == 3'd7) state_d = PUBLISH;
      default: state_d = ACCUM;
    endcase
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [LEVEL_W-1:0] held_cur, decayed;
`else
  logic [7:0] decay_unused;
  assign decay_unused = 8'(DECAY_STEP);
`endif

  always_comb begin
    avg     = sum_q[b_q] >> b_q;
    lvl     = avg >> LEVEL_SHIFT;
    new_lvl = (lvl > SUM_W'(255)) ? 8'hFF : lvl[LEVEL_W-1:0];
`ifdef SPECTRUM_PEAK_HOLD_EN
    held_cur = held_q[b_q];
    decayed  = (held_cur > 8'(DECAY_STEP)) ? held_cur - 8'(DECAY_STEP) : 8'd0;
    // When new >= held, decayed <= new, so max() covers the rising case as well.
    upd_lvl  = (decayed > new_lvl) ? decayed : new_lvl;
`else
    upd_lvl  = new_lvl;
`endif
    held_d = held_q;
    if (state_q == FINAL) held_d[b_q] = upd_lvl;
    flat_d = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      flat_d[k*LEVEL_W +: LEVEL_W] = held_d[k];
    end
  end

  log2_fixed #(.W(TOT_W)) u_log2 (
    .x_i (total_q),
    .y_o (db_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= 8'd0;
      full_q  <= 1'b0;
      b_q     <= 3'd0;
      total_q <= '0;
      flat_q  <= '0;
      db_q    <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) begin
        sum_q[k]  <= '0;
        held_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      valid_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          b_q <= 3'd0;
          if (take) begin
            sum_q[band_of(idx_q)] <= sum_q[band_of(idx_q)] + SUM_W'(bin_data);
            total_q               <= total_q + TOT_W'(bin_data);
          end
          if (xfer) begin
            if (idx_q == 8'hFF) full_q <= 1'b1;
            else                idx_q  <= idx_q + 8'd1;
          end
        end
        FINAL: begin
          b_q <= b_q + 3'd1;
          // Outputs take the last band's fresh level here so they are new during PUBLISH.
          if (b_q == 3'd7) begin
            flat_q  <= flat_d;
            db_q    <= db_d;
            valid_q <= 1'b1;
          end
        end
        default: begin
          idx_q   <= 8'd0;
          full_q  <= 1'b0;
          total_q <= '0;
          for (int k = 0; k < NUM_BANDS; k++) sum_q[k] <= '0;
        end
      endcase
    end
  end

  assign spectrum_data_flat = flat_q;
  assign db_value           = db_q;
  assign spectrum_valid     = valid_q;

endmodule

// File: tb/tb_spectrum_band_builder.sv
// Randomised frames against a plain-arithmetic band/log2 model, plus the directed frame cases.
module tb_spectrum_band_builder;

  logic        clk = 1'b0;
  logic        rst, bin_valid, bin_last, bin_ready, spectrum_valid;
  logic [15:0] bin_data, db_value;
  logic [63:0] spectrum_data_flat;

  int          n_total = 0;
  int          n_bad   = 0;
  int unsigned frame_v[$];
  int          model_held[8];

  spectrum_band_builder dut (
    .clk                (clk),
    .rst                (rst),
    .bin_valid          (bin_valid),
    .bin_data           (bin_data),
    .bin_last           (bin_last),
    .bin_ready          (bin_ready),
    .spectrum_data_flat (spectrum_data_flat),
    .db_value           (db_value),
    .spectrum_valid     (spectrum_valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    bin_valid = 1'b0;
    bin_last  = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) model_held[k] = 0;
  endtask

  // Drives frame_v; returns cycles from bin_last acceptance to the strobe and how often ready was seen high meanwhile.
  task automatic run_frame(input bit send_last, input bit hold_after, input logic [15:0] hold_data,
                           output int lat, output int ready_hi,
                           output logic [63:0] o_flat, output logic [15:0] o_db);
    int n, guard;
    n = frame_v.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 4) == 0) begin
        bin_valid = 1'b0;
        @(posedge clk); #1;
      end
      bin_valid = 1'b1;
      bin_data  = 16'(frame_v[i]);
      bin_last  = send_last && (i == n - 1);
      @(negedge clk);
      guard = 0;
      while (!bin_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk); #1;
    end
    bin_last = 1'b0;
    if (hold_after) bin_data = hold_data;
    else            bin_valid = 1'b0;
    lat      = 0;
    ready_hi = 0;
    o_flat   = '0;
    o_db     = '0;
    if (!send_last) return;
    lat = 1;
    while (lat <= 30) begin
      @(negedge clk);
      if (bin_ready) ready_hi++;
      if (spectrum_valid) break;
      lat++;
    end
    o_flat = spectrum_data_flat;
    o_db   = db_value;
  endtask

  // Reference: band k = floor(log2 i) for i in 1..255, averages by division, log2 by magnitude search.
  task automatic model_frame(output logic [63:0] e_flat, output logic [15:0] e_db);
    longint unsigned sums[8];
    longint unsigned tot, lvl, mant;
    int m;
    tot = 0;
    for (int k = 0; k < 8; k++) sums[k] = 0;
    for (int i = 1; i < frame_v.size() && i < 256; i++) begin
      int k;
      k = 0;
      while ((i >> (k + 1)) != 0) k++;
      sums[k] += frame_v[i];
      tot     += frame_v[i];
    end
    e_flat = '0;
    for (int k = 0; k < 8; k++) begin
      lvl = (sums[k] / (64'd1 << k)) / 16;
      if (lvl > 255) lvl = 255;
`ifdef SPECTRUM_PEAK_HOLD_EN
      if (int'(lvl) >= model_held[k]) model_held[k] = int'(lvl);
      else model_held[k] = (model_held[k] - 8 > int'(lvl)) ? model_held[k] - 8 : int'(lvl);
`else
      model_held[k] = int'(lvl);
`endif
      e_flat[k*8 +: 8] = 8'(model_held[k]);
    end
    if (tot == 0) e_db = 16'h0000;
    else begin
      m = 0;
      for (int b = 0; b < 40; b++) if (tot >= (64'd1 << b)) m = b;
      if (m >= 8) mant = (tot >> (m - 8)) % 256;
      else        mant = (tot << (8 - m)) % 256;
      e_db = {8'(m), 8'(mant)};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bin_valid = 1'b0; bin_last = 1'b0; bin_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (spectrum_data_flat !== 64'h0) begin n_bad++; $display("FAIL reset_flat got=%h want=0", spectrum_data_flat); end
    n_total++; if (db_value !== 16'h0) begin n_bad++; $display("FAIL reset_db got=%h want=0", db_value); end
    n_total++; if (spectrum_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", spectrum_valid); end
    n_total++; if (bin_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_rst got=%b want=0", bin_ready); end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) model_held[k] = 0;
    @(negedge clk);
    n_total++; if (bin_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after got=%b want=1", bin_ready); end
  endtask

  task automatic test_flat_frame();
    int lat, rh;
    logic [63:0] f, ef;
    logic [15:0] d, ed;
    frame_v.delete();
    for (int i = 0; i < 256; i++) frame_v.push_back(32'h0100);
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    model_frame(ef, ed);
    n_total++; if (lat !== 9) begin n_bad++; $display("FAIL flat_latency got=%0d want=9", lat); end
    n_total++; if (rh !== 0) begin n_bad++; $display("FAIL flat_ready_low got=%0d want=0", rh); end
    n_total++; if (f !== 64'h1010_1010_1010_1010) begin n_bad++; $display("FAIL flat_bands got=%h want=1010101010101010", f); end
    n_total++; if (d !== 16'h0FFE) begin n_bad++; $display("FAIL flat_db got=%h want=0ffe", d); end
    n_total++; if (f !== ef || d !== ed) begin n_bad++; $display("FAIL flat_model got=%h/%h want=%h/%h", f, d, ef, ed); end
    @(negedge clk);
    n_total++; if (spectrum_valid !== 1'b0 || bin_ready !== 1'b1 || spectrum_data_flat !== f) begin
      n_bad++; $display("FAIL flat_after_strobe got=v%b r%b %h want=v0 r1 %h", spectrum_valid, bin_ready, spectrum_data_flat, f);
    end
  endtask

  task automatic test_saturation_decay();
    int lat, rh, exp2, exp3;
    logic [63:0] f;
    logic [15:0] d;
`ifdef SPECTRUM_PEAK_HOLD_EN
    exp2 = 247; exp3 = 239;
`else
    exp2 = 0;   exp3 = 0;
`endif
    do_reset();
    frame_v.delete();
    frame_v.push_back(32'h0); frame_v.push_back(32'hFFFF);
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    n_total++; if (f !== 64'h0000_0000_0000_00FF) begin n_bad++; $display("FAIL sat_frame1 got=%h want=ff", f); end
    n_total++; if (d !== 16'h0FFF) begin n_bad++; $display("FAIL sat_db got=%h want=0fff", d); end
    frame_v.delete();
    frame_v.push_back(32'h0); frame_v.push_back(32'h0);
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    n_total++; if (int'(f[7:0]) !== exp2) begin n_bad++; $display("FAIL decay_frame2 got=%0d want=%0d", f[7:0], exp2); end
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    n_total++; if (int'(f[7:0]) !== exp3) begin n_bad++; $display("FAIL decay_frame3 got=%0d want=%0d", f[7:0], exp3); end
    n_total++; if (d !== 16'h0) begin n_bad++; $display("FAIL decay_db got=%h want=0", d); end
  endtask

  task automatic test_single_high();
    int lat, rh;
    logic [63:0] f;
    logic [15:0] d;
    do_reset();
    frame_v.delete();
    for (int i = 0; i <= 200; i++) frame_v.push_back(i == 200 ? 32'h1000 : 32'h0);
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    n_total++; if (f !== 64'h0200_0000_0000_0000) begin n_bad++; $display("FAIL high_bands got=%h want=0200000000000000", f); end
    n_total++; if (d !== 16'h0C00) begin n_bad++; $display("FAIL high_db got=%h want=0c00", d); end
  endtask

  task automatic test_short_frame();
    int lat, rh;
    logic [63:0] f;
    logic [15:0] d;
    do_reset();
    frame_v.delete();
    for (int i = 0; i < 4; i++) frame_v.push_back(32'h0040);
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    n_total++; if (f !== 64'h0000_0000_0000_0404) begin n_bad++; $display("FAIL short_bands got=%h want=0404", f); end
    n_total++; if (d !== 16'h0780) begin n_bad++; $display("FAIL short_db got=%h want=0780", d); end
    n_total++; if (lat !== 9) begin n_bad++; $display("FAIL short_latency got=%0d want=9", lat); end
  endtask

  task automatic test_single_bin();
    int lat, rh;
    logic [63:0] f;
    logic [15:0] d;
    do_reset();
    frame_v.delete();
    frame_v.push_back(32'hBEEF);
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    n_total++; if (lat !== 9) begin n_bad++; $display("FAIL single_strobe got=%0d want=9", lat); end
    n_total++; if (f !== 64'h0 || d !== 16'h0) begin n_bad++; $display("FAIL single_out got=%h/%h want=0/0", f, d); end
  endtask

  task automatic test_back_to_back();
    int lat, rh;
    logic [63:0] f, ef;
    logic [15:0] d, ed, y;
    frame_v.delete();
    for (int i = 0; i < 4; i++) frame_v.push_back($urandom_range(0, 16'hFFFF));
    run_frame(1'b1, 1'b1, 16'h7777, lat, rh, f, d);
    model_frame(ef, ed);
    n_total++; if (rh !== 0) begin n_bad++; $display("FAIL bp_ready_low got=%0d want=0", rh); end
    n_total++; if (f !== ef || d !== ed) begin n_bad++; $display("FAIL bp_frameA got=%h/%h want=%h/%h", f, d, ef, ed); end
    y = 16'($urandom_range(16'h0100, 16'hFFFF));
    frame_v.delete();
    frame_v.push_back(32'h7777); frame_v.push_back(32'(y));
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    model_frame(ef, ed);
    n_total++; if (f !== ef || d !== ed) begin n_bad++; $display("FAIL bp_frameB got=%h/%h want=%h/%h", f, d, ef, ed); end
  endtask

  task automatic test_reset_mid_frame();
    int lat, rh, strobes;
    logic [63:0] f;
    logic [15:0] d;
    frame_v.delete();
    for (int i = 0; i < 100; i++) frame_v.push_back($urandom_range(0, 16'hFFFF));
    run_frame(1'b0, 1'b0, 16'h0, lat, rh, f, d);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (spectrum_data_flat !== 64'h0 || db_value !== 16'h0 || spectrum_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs got=%h/%h/%b want=0/0/0", spectrum_data_flat, db_value, spectrum_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) model_held[k] = 0;
    strobes = 0;
    repeat (12) begin
      @(negedge clk);
      if (spectrum_valid) strobes++;
    end
    n_total++; if (strobes !== 0) begin n_bad++; $display("FAIL midrst_strobe got=%0d want=0", strobes); end
    frame_v.delete();
    for (int i = 0; i < 256; i++) frame_v.push_back(32'h0100);
    run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
    n_total++; if (f !== 64'h1010_1010_1010_1010 || d !== 16'h0FFE) begin
      n_bad++; $display("FAIL midrst_flat got=%h/%h want=1010101010101010/0ffe", f, d);
    end
  endtask

  task automatic test_random();
    int lat, rh, n;
    int unsigned mask;
    logic [63:0] f, ef;
    logic [15:0] d, ed;
    for (int fr = 0; fr < 8; fr++) begin
      n = $urandom_range(1, 300);
      case ($urandom_range(0, 2))
        0:       mask = 32'hFFFF;
        1:       mask = 32'h0FFF;
        default: mask = 32'h00FF;
      endcase
      frame_v.delete();
      for (int i = 0; i < n; i++) frame_v.push_back($urandom() & mask);
      run_frame(1'b1, 1'b0, 16'h0, lat, rh, f, d);
      model_frame(ef, ed);
      n_total++; if (lat !== 9) begin n_bad++; $display("FAIL rand_latency frame=%0d got=%0d want=9", fr, lat); end
      n_total++; if (f !== ef) begin n_bad++; $display("FAIL rand_bands frame=%0d len=%0d got=%h want=%h", fr, n, f, ef); end
      n_total++; if (d !== ed) begin n_bad++; $display("FAIL rand_db frame=%0d len=%0d got=%h want=%h", fr, n, d, ed); end
    end
  endtask

  initial begin
    test_reset();
    test_flat_frame();
    test_saturation_decay();
    test_single_high();
    test_short_frame();
    test_single_bin();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
